// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, NOP instruction word
// and the default multiply/divide stall length.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR         = 32'h0;
  localparam int          MD_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: the EX load writes a register the ID instruction reads.
// Register 0 is hardwired to zero, so a load "to" r0 never creates a hazard.
module load_use_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  // pure combinational match against both ID source fields
  always_comb begin
    load_use = ex_memread & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall, instruction-memory
// wait and multi-cycle multiply/divide stall, plus a saturating stall counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | normal issue; branch > load-use > imem wait > advance
// ST_MD_WAIT | mult/div in flight; pipeline frozen for MD_CYCLES cycles
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_md_start,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);

  // Counter is loaded with MD_CYCLES-1 so that the terminal count (0) is the
  // last stalled cycle, giving exactly MD_CYCLES cycles in ST_MD_WAIT.
  localparam logic [7:0] MD_CNT_INIT = 8'(MD_CYCLES - 1);

  hz_state_e   state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, md_busy_c;

  load_use_detect u_load_use_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // next-state, down-counter and Mealy output decode
  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    pc_write_c    = 1'b0;
    ifid_write_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    md_busy_c     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          pc_write_c    = 1'b1;
          ifid_write_c  = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (load_use) begin
          // mult/div is held off here; ID re-presents it next cycle
          idex_bubble_c = 1'b1;
        end else begin
          if (!imem_ready) begin
            ifid_write_c = 1'b1;
            ifid_flush_c = 1'b1;
          end else begin
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
          end
          if (id_md_start) begin
            state_d  = ST_MD_WAIT;
            md_cnt_d = MD_CNT_INIT;
          end
        end
      end
      ST_MD_WAIT: begin
        idex_bubble_c = 1'b1;
        md_busy_c     = 1'b1;
        if (md_cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // outputs are forced low while reset is held, not just the registers
  always_comb begin
    pc_write    = pc_write_c    & ~reset;
    ifid_write  = ifid_write_c  & ~reset;
    ifid_flush  = ifid_flush_c  & ~reset;
    idex_bubble = idex_bubble_c & ~reset;
    md_busy     = md_busy_c     & ~reset;
  end

  // saturating count of cycles in which the PC did not advance
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // state, counter and stall-count registers with async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      md_cnt_q       <= 8'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change on the falling edge,
// combinational outputs are sampled 1 time unit later, state commits on the
// following rising edge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_md_start, ex_memread, ex_branch_taken, imem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
  logic [15:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_md_start     (id_md_start),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .md_busy         (md_busy),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pc_write, ifid_write, ifid_flush, idex_bubble, md_busy as one 5-bit vector
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, 16'({pc_write, ifid_write, ifid_flush, idex_bubble, md_busy}), 16'(exp));
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; id_md_start = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic step_in();
    @(negedge clk);
    idle();
  endtask

  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_LU     = 5'b00010;
  localparam logic [4:0] C_BR     = 5'b11110;
  localparam logic [4:0] C_IMEM   = 5'b01100;
  localparam logic [4:0] C_MDWAIT = 5'b00011;
  localparam logic [4:0] C_ZERO   = 5'b00000;

  initial begin
    idle();
    reset = 1'b1;
    #2;
    check_ctl("reset_outputs", C_ZERO);
    check("reset_stall", stall_cycles, 16'd0);

    @(negedge clk); reset = 1'b0; #1;
    check_ctl("after_reset_run", C_RUN);

    // load-use via rs: one stall cycle
    step_in(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
    check_ctl("lu_rs_stall", C_LU);
    step_in(); #1;
    check_ctl("lu_rs_release", C_RUN);
    check("lu_rs_stall_cnt", stall_cycles, 16'd1);

    // ex_rt = 0 never hazards
    step_in(); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
    check_ctl("lu_r0_none", C_RUN);
    // rt match but rt not a source
    step_in(); ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; #1;
    check_ctl("lu_rt_unused", C_RUN);
    // rt match with rt used
    step_in(); ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1; #1;
    check_ctl("lu_rt_used", C_LU);
    step_in(); #1;
    check("lu_rt_stall_cnt", stall_cycles, 16'd2);

    // branch overrides load-use and mult/div start
    step_in(); ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    id_md_start = 1'b1; #1;
    check_ctl("branch_priority", C_BR);
    step_in(); #1;
    check_ctl("branch_stays_run", C_RUN);
    check("branch_stall_cnt", stall_cycles, 16'd2);

    // load-use blocks mult/div acceptance
    step_in(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_md_start = 1'b1; #1;
    check_ctl("lu_blocks_md", C_LU);
    step_in(); #1;
    check_ctl("md_not_accepted", C_RUN);
    check("lu_md_stall_cnt", stall_cycles, 16'd3);

    // instruction memory not ready for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step_in(); imem_ready = 1'b0; #1;
      check_ctl($sformatf("imem_wait_%0d", i), C_IMEM);
    end
    step_in(); #1;
    check_ctl("imem_resume", C_RUN);
    check("imem_stall_cnt", stall_cycles, 16'd6);

    // mult/div: 4 frozen cycles, inputs ignored meanwhile
    step_in(); id_md_start = 1'b1; #1;
    check_ctl("md_issue", C_RUN);
    for (int i = 0; i < 4; i++) begin
      step_in(); ex_branch_taken = 1'b1; id_md_start = 1'b1; imem_ready = 1'b0; #1;
      check_ctl($sformatf("md_wait_%0d", i), C_MDWAIT);
    end
    step_in(); #1;
    check_ctl("md_done", C_RUN);
    check("md_stall_cnt", stall_cycles, 16'd10);

    // mult/div accepted during imem wait, reset in 2nd MD_WAIT cycle
    step_in(); imem_ready = 1'b0; id_md_start = 1'b1; #1;
    check_ctl("md_issue_imem", C_IMEM);
    step_in(); #1;
    check_ctl("md_wait_a", C_MDWAIT);
    step_in(); #1;
    check_ctl("md_wait_b", C_MDWAIT);
    check("pre_reset_stall", stall_cycles, 16'd12);
    #1 reset = 1'b1; #1;
    check_ctl("async_reset_outputs", C_ZERO);
    check("async_reset_stall", stall_cycles, 16'd0);
    @(posedge clk); #1;
    check_ctl("held_reset_outputs", C_ZERO);
    @(negedge clk); reset = 1'b0; #1;
    check_ctl("post_reset_run", C_RUN);
    step_in(); #1;
    check_ctl("post_reset_run2", C_RUN);
    check("post_reset_stall", stall_cycles, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_CYCLES, default 4, meaning the stall length in cycles after a multiply/divide issue; legal range 1..255.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  reset; asynchronous, active-high.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 id_uses_rt  input  1  the ID instruction reads rt as a source.
REQ-007 id_md_start  input  1  the ID instruction is a mult/div.
REQ-008 ex_memread  input  1  the EX instruction is a load.
REQ-009 ex_rt  input  5  destination register of the EX load.
REQ-010 ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-011 imem_ready  input  1  instruction memory data is valid this cycle.
REQ-012 pc_write  output  1  PC loads its next value.
REQ-013 ifid_write  output  1  IF/ID register loads.
REQ-014 ifid_flush  output  1  IF/ID loads 32'h0 (NOP) instead of fetched data.
REQ-015 idex_bubble  output  1  ID/EX control fields load zero.
REQ-016 md_busy  output  1  multiply/divide stall in progress.
REQ-017 stall_cycles  output  16  count of cycles with pc_write=0.

Function
REQ-018 The FSM SHALL have two states, RUN and MD_WAIT, plus an 8-bit down-counter md_cnt.
REQ-019 load_use SHALL be ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
REQ-020 The outputs SHALL be combinational from state and inputs (Mealy), with the following RUN priority, highest first.
REQ-021 RUN, ex_branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; load_use and id_md_start are ignored.
REQ-022 RUN, load_use=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1; id_md_start is not accepted (it is re-presented next cycle).
REQ-023 RUN, imem_ready=0: pc_write=0, ifid_write=1, ifid_flush=1, idex_bubble=0.
REQ-024 RUN, otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-025 id_md_start SHALL be accepted in the REQ-023 and REQ-024 cases: next state MD_WAIT, md_cnt <= MD_CYCLES-1.
REQ-026 MD_WAIT: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, md_busy=1; all data inputs are ignored.
REQ-027 In MD_WAIT, md_cnt SHALL decrement each cycle; md_cnt==0 SHALL give next state RUN. Total stall = exactly MD_CYCLES cycles.
REQ-028 md_busy SHALL be 0 in RUN.
REQ-029 stall_cycles SHALL increment each cycle pc_write=0 and SHALL saturate at 16'hFFFF.

Reset
REQ-030 reset SHALL force state RUN, md_cnt=0 and stall_cycles=0 immediately, including mid-MD_WAIT.
REQ-031 While reset=1, all outputs SHALL be 0.
REQ-032 The first edge after reset deasserts SHALL evaluate RUN rules.

Structure
REQ-033 The shared pipeline package SHALL hold the state encoding, the NOP constant 32'h0 and the MD_CYCLES default.
REQ-034 The load_use compare SHALL be a sub-module load_use_detect (pure combinational); the FSM, counter and output decode SHALL stay in pipe_hazard_ctrl.

Verification
REQ-035 ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> exactly one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1.
REQ-036 Same as REQ-035 but ex_rt=0 -> no stall; ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
REQ-037 ex_branch_taken=1 together with a load_use match and id_md_start=1 -> ifid_flush=1, idex_bubble=1, pc_write=1; state stays RUN.
REQ-038 MD_CYCLES=4, id_md_start=1 in RUN -> md_busy=1 for 4 cycles, then pc_write=1 with md_busy=0; stall_cycles=4.
REQ-039 imem_ready=0 for 3 cycles -> pc_write=0 and ifid_flush=1 on each cycle, ifid_write=1; stall_cycles=3.
REQ-040 reset pulsed in the 2nd MD_WAIT cycle -> outputs and stall_cycles go to 0 asynchronously; after release, RUN with pc_write=1.
